// File: rtl/ram_pkg.sv
// Shared definitions for the banked RAM: sequencer state encoding and
// helpers that derive address width and depth from the bank parameters.
package ram_pkg;

  typedef enum logic {
    LIMPANDO = 1'b0,
    OCIOSO   = 1'b1
  } estado_t;

  // Full word-address width from bank-select and word-in-bank widths.
  function automatic int calc_bits_end(input int bits_banco, input int bits_palavra);
    return bits_banco + bits_palavra;
  endfunction

  // Total number of words in the memory.
  function automatic int calc_profundidade(input int bits_banco, input int bits_palavra);
    return 2 ** (bits_banco + bits_palavra);
  endfunction

endpackage

// File: rtl/ram_banco.sv
// One RAM bank: synchronous write, combinational read.
module ram_banco #(
  parameter int LARGURA      = 16,
  parameter int BITS_PALAVRA = 3
) (
  input  logic                    clock_principal,
  input  logic                    habilita_write,
  input  logic [BITS_PALAVRA-1:0] endereco_palavra,
  input  logic [LARGURA-1:0]      dados_entrada,
  output logic [LARGURA-1:0]      dados_saida
);

  logic [LARGURA-1:0] mem [2**BITS_PALAVRA];

  // Word write on the rising edge when this bank is selected.
  // NOTE: the storage array has no reset branch; clearing is done by the
  // top-level sequencer so the array maps onto plain RAM cells.
  always_ff @(posedge clock_principal) begin
    if (habilita_write) begin
      mem[endereco_palavra] <= dados_entrada;
    end
  end

  assign dados_saida = mem[endereco_palavra];

endmodule

// File: rtl/ram_bancos_param.sv
// Banked single-port RAM with zero-fill sequencer, ready flag and a
// registered, write-first read path with a one-cycle valid strobe.
module ram_bancos_param
  import ram_pkg::*;
#(
  parameter int LARGURA      = 16,
  parameter int BITS_BANCO   = 3,
  parameter int BITS_PALAVRA = 3,
  localparam int BITS_END    = calc_bits_end(BITS_BANCO, BITS_PALAVRA)
) (
  input  logic                clock_principal,
  input  logic                reset_n,
  input  logic [LARGURA-1:0]  dados_entrada,
  input  logic [BITS_END-1:0] endereco_acesso,
  input  logic                controle_write,
  input  logic                controle_read,
  input  logic                comando_limpar,
  output logic                pronto,
  output logic [LARGURA-1:0]  dados_saida,
  output logic                saida_valida
);

  localparam int NUM_BANCOS   = 2 ** BITS_BANCO;
  localparam int PROFUNDIDADE = calc_profundidade(BITS_BANCO, BITS_PALAVRA);
  localparam logic [BITS_END-1:0] ULTIMO_END = BITS_END'(PROFUNDIDADE - 1);

  estado_t             estado;
  logic [BITS_END-1:0] contador;

  logic                aceita;
  logic                escrita_usuario;
  logic                leitura_usuario;
  logic                escreve;
  logic [BITS_END-1:0] end_mem;
  logic [LARGURA-1:0]  dado_mem;
  logic [BITS_BANCO-1:0] banco_sel;
  logic [NUM_BANCOS-1:0] habilita;
  logic [LARGURA-1:0]  saidas_bancos [NUM_BANCOS];
  logic [LARGURA-1:0]  dado_lido;

  // Select between clear path and user path, and qualify user requests.
  // NOTE: every signal gets a default first so no path leaves a latch.
  always_comb begin
    aceita          = 1'b0;
    escrita_usuario = 1'b0;
    leitura_usuario = 1'b0;
    escreve         = 1'b0;
    end_mem         = endereco_acesso;
    dado_mem        = dados_entrada;
    // A clear command or reset drops any same-cycle user request.
    aceita          = (estado == OCIOSO) && !comando_limpar && reset_n;
    escrita_usuario = aceita && controle_write;
    leitura_usuario = aceita && controle_read;
    if (estado == LIMPANDO) begin
      end_mem  = contador;
      dado_mem = '0;
      escreve  = reset_n;
    end else begin
      escreve  = escrita_usuario;
    end
  end

  // Write-enable decoder: only the addressed bank sees the enable.
  always_comb begin
    banco_sel = end_mem[BITS_END-1:BITS_PALAVRA];
    habilita  = '0;
    for (int b = 0; b < NUM_BANCOS; b++) begin
      habilita[b] = escreve && (banco_sel == BITS_BANCO'(b));
    end
  end

  for (genvar g = 0; g < NUM_BANCOS; g++) begin : g_banco
    ram_banco #(
      .LARGURA      (LARGURA),
      .BITS_PALAVRA (BITS_PALAVRA)
    ) u_banco (
      .clock_principal  (clock_principal),
      .habilita_write   (habilita[g]),
      .endereco_palavra (end_mem[BITS_PALAVRA-1:0]),
      .dados_entrada    (dado_mem),
      .dados_saida      (saidas_bancos[g])
    );
  end

  // Bank output mux driven by the bank field of the user address.
  always_comb begin
    dado_lido = saidas_bancos[endereco_acesso[BITS_END-1:BITS_PALAVRA]];
  end

  // Clear sequencer plus registered read outputs.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_principal) begin
    if (!reset_n) begin
      estado       <= LIMPANDO;
      contador     <= '0;
      pronto       <= 1'b0;
      saida_valida <= 1'b0;
      dados_saida  <= '0;
    end else begin
      saida_valida <= leitura_usuario;
      if (leitura_usuario) begin
        // Write-first: the array still holds the old word this cycle.
        dados_saida <= controle_write ? dados_entrada : dado_lido;
      end
      case (estado)
        LIMPANDO: begin
          if (comando_limpar) begin
            contador <= '0;
          end else begin
            contador <= contador + 1'b1;
            if (contador == ULTIMO_END) begin
              estado <= OCIOSO;
              pronto <= 1'b1;
            end
          end
        end
        OCIOSO: begin
          if (comando_limpar) begin
            estado   <= LIMPANDO;
            contador <= '0;
            pronto   <= 1'b0;
          end
        end
        default: begin
          estado <= LIMPANDO;
          pronto <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bancos_param.sv
// Directed bench: drives a default (16/3/3) and a narrow (8/2/4) instance
// from the same stimulus; both have 64 words and a 6-bit address.
module tb_ram_bancos_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] din;
  logic [5:0]  addr;
  logic        wr, rd, clr;

  logic        pronto_a, valida_a;
  logic [15:0] dout_a;
  logic        pronto_b, valida_b;
  logic [7:0]  dout_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_bancos_param #(.LARGURA(16), .BITS_BANCO(3), .BITS_PALAVRA(3)) dut_a (
    .clock_principal (clk),
    .reset_n         (reset_n),
    .dados_entrada   (din),
    .endereco_acesso (addr),
    .controle_write  (wr),
    .controle_read   (rd),
    .comando_limpar  (clr),
    .pronto          (pronto_a),
    .dados_saida     (dout_a),
    .saida_valida    (valida_a)
  );

  ram_bancos_param #(.LARGURA(8), .BITS_BANCO(2), .BITS_PALAVRA(4)) dut_b (
    .clock_principal (clk),
    .reset_n         (reset_n),
    .dados_entrada   (din[7:0]),
    .endereco_acesso (addr),
    .controle_write  (wr),
    .controle_read   (rd),
    .comando_limpar  (clr),
    .pronto          (pronto_b),
    .dados_saida     (dout_b),
    .saida_valida    (valida_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until pronto rises; expects exactly 64 and no strobe.
  task automatic wait_clear(input string nome);
    int n = 0;
    bit saw_valid = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (valida_a || valida_b) saw_valid = 1'b1;
      if (pronto_a || pronto_b) break;
    end
    wr = 1'b0;
    rd = 1'b0;
    tests++;
    if (n != 64 || pronto_a !== 1'b1 || pronto_b !== 1'b1) begin
      fails++;
      $display("FAIL %s_clear_len: cycles=%0d pronto=%b/%b expected 64 cycles pronto=1/1",
               nome, n, pronto_a, pronto_b);
    end
    tests++;
    if (saw_valid) begin
      fails++;
      $display("FAIL %s_no_valid_in_clear: saida_valida seen=1 expected 0", nome);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    addr = a; din = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic read_check(input logic [5:0] a, input logic [15:0] exp);
    logic [7:0] exp_b;
    exp_b = exp[7:0];
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    tests++;
    if (valida_a !== 1'b1 || valida_b !== 1'b1 || dout_a !== exp || dout_b !== exp_b) begin
      fails++;
      $display("FAIL read_%h: valid=%b/%b data=%h/%h expected 1/1 %h/%h",
               a, valida_a, valida_b, dout_a, dout_b, exp, exp_b);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clr = 1'b0; wr = 1'b1; rd = 1'b1; din = 16'hFFFF; addr = 6'h20;
    tick();
    tests++;
    if (pronto_a !== 1'b0 || pronto_b !== 1'b0 || valida_a !== 1'b0 || valida_b !== 1'b0 ||
        dout_a !== 16'h0 || dout_b !== 8'h0) begin
      fails++;
      $display("FAIL reset_state: pronto=%b/%b valid=%b/%b data=%h/%h expected all 0",
               pronto_a, pronto_b, valida_a, valida_b, dout_a, dout_b);
    end
    // Write 0xFFFF@0x20 and read requests held during the whole clear.
    reset_n = 1'b1;
    wait_clear("reset");
    read_check(6'h2A, 16'h0000);
    read_check(6'h20, 16'h0000);
  endtask

  task automatic test_write_read();
    do_write(6'h09, 16'hBEEF);
    do_write(6'h3F, 16'h1234);
    do_write(6'h00, 16'hA5A5);
    read_check(6'h09, 16'hBEEF);
    read_check(6'h3F, 16'h1234);
    read_check(6'h00, 16'hA5A5);
    read_check(6'h08, 16'h0000);
    read_check(6'h0A, 16'h0000);
    read_check(6'h31, 16'h0000);
    read_check(6'h09, 16'hBEEF);
    // No request: strobe drops, data holds.
    tick();
    tests++;
    if (valida_a !== 1'b0 || valida_b !== 1'b0 || dout_a !== 16'hBEEF || dout_b !== 8'hEF) begin
      fails++;
      $display("FAIL idle_hold: valid=%b/%b data=%h/%h expected 0/0 beef/ef",
               valida_a, valida_b, dout_a, dout_b);
    end
  endtask

  task automatic test_same_cycle();
    addr = 6'h12; din = 16'h5555; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    tests++;
    if (valida_a !== 1'b1 || valida_b !== 1'b1 || dout_a !== 16'h5555 || dout_b !== 8'h55) begin
      fails++;
      $display("FAIL write_first: valid=%b/%b data=%h/%h expected 1/1 5555/55",
               valida_a, valida_b, dout_a, dout_b);
    end
    read_check(6'h12, 16'h5555);
  endtask

  task automatic test_clear_cmd();
    do_write(6'h15, 16'h7777);
    read_check(6'h15, 16'h7777);
    addr = 6'h16; din = 16'h1111; wr = 1'b1; clr = 1'b1;
    tick();
    wr = 1'b0; clr = 1'b0;
    tests++;
    if (pronto_a !== 1'b0 || pronto_b !== 1'b0) begin
      fails++;
      $display("FAIL clear_cmd_pronto: pronto=%b/%b expected 0/0", pronto_a, pronto_b);
    end
    wait_clear("cmd");
    read_check(6'h15, 16'h0000);
    read_check(6'h16, 16'h0000);
    // Restart in the middle of a clear: 64 more cycles from the pulse.
    do_write(6'h3E, 16'hC0DE);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_clear("restart");
    read_check(6'h3E, 16'h0000);
  endtask

  task automatic test_reset_mid();
    do_write(6'h05, 16'h9ABC);
    read_check(6'h05, 16'h9ABC);
    // Reset on the same edge as a read: strobe cancelled, data zeroed.
    addr = 6'h05; rd = 1'b1; reset_n = 1'b0;
    tick();
    rd = 1'b0;
    tests++;
    if (valida_a !== 1'b0 || valida_b !== 1'b0 || dout_a !== 16'h0 || dout_b !== 8'h0 ||
        pronto_a !== 1'b0 || pronto_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_read: valid=%b/%b data=%h/%h pronto=%b/%b expected all 0",
               valida_a, valida_b, dout_a, dout_b, pronto_a, pronto_b);
    end
    reset_n = 1'b1;
    repeat (30) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_clear("reset_mid_clear");
    read_check(6'h05, 16'h0000);
  endtask

  initial begin
    reset_n = 1'b0; din = '0; addr = '0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_clear_cmd();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_bancos_param.md
Name: ram_bancos_param

Overview:
- Parametrised, banked single-port RAM. Generalises the fixed 64×16 RAM (8 banks of RAM8, dmux on write enable, 8-way mux on output) to configurable word width, bank count and bank depth.
- Adds a synchronous active-low reset, a hardware clear sequencer (zero-fill after reset or on command), and a ready handshake.
- Adds a registered read path with a valid strobe.
- Sits between the CPU datapath and program/data memory; drop-in replacement where a cleared memory with known read timing is required.

Parameters:
- LARGURA, 16, data word width in bits (>=1)
- BITS_BANCO, 3, bank-select address bits; bank count = 2^BITS_BANCO
- BITS_PALAVRA, 3, word-in-bank address bits; words per bank = 2^BITS_PALAVRA
- (derived) BITS_END = BITS_BANCO+BITS_PALAVRA; PROFUNDIDADE = 2^BITS_END

Ports:
- clock_principal  in  1  sole clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- dados_entrada  in  LARGURA  write data
- endereco_acesso  in  BITS_END  word address; [BITS_END-1:BITS_PALAVRA] = bank, [BITS_PALAVRA-1:0] = word
- controle_write  in  1  write request
- controle_read  in  1  read request
- comando_limpar  in  1  start zero-fill of entire memory (one-cycle pulse sufficient)
- pronto  out  1  high = requests accepted; low during clear
- dados_saida  out  LARGURA  registered read data
- saida_valida  out  1  one-cycle strobe, dados_saida valid

Behaviour:
- Reset (reset_n=0 at edge): pronto=0, saida_valida=0, dados_saida=0, clear counter=0, state=LIMPANDO. Memory contents are not reset directly; they are zeroed by the sequencer.
- States: LIMPANDO, OCIOSO.
- LIMPANDO:
  - Each cycle writes 0 to address = counter, then counter++.
  - When counter = PROFUNDIDADE-1 has been written, the state moves to OCIOSO on the next edge and pronto rises.
  - The clear takes exactly PROFUNDIDADE cycles; the first accepted request is at cycle PROFUNDIDADE after reset release.
  - Requests while pronto=0 are ignored: no write, no saida_valida.
- OCIOSO:
  - Sampled at each edge: pronto=1.
  - controle_write=1: the bank decoded from the upper address bits gets the write enable; the word is written at that edge. All other banks are unaffected.
  - controle_read=1: dados_saida <= mem[endereco_acesso], saida_valida=1 on the next cycle (latency 1). saida_valida is 0 in every cycle with no accepted read.
  - Read and write in the same cycle (single address): write-first. dados_saida returns the new dados_entrada.
  - comando_limpar=1: state returns to LIMPANDO, counter=0, pronto=0 from the next cycle. Takes priority over any same-cycle read/write, which are dropped.
- comando_limpar during LIMPANDO: restarts the counter at 0.
- reset_n=0 during LIMPANDO or mid-operation: same as reset. A pending read strobe is cancelled (saida_valida=0 next cycle).
- dados_saida holds its last value when saida_valida=0. It resets to 0 only via reset_n.
- Address is always in range (power-of-two depth); the counter wraps naturally only on restart.

Decomposition:
- Shared package ram_pkg:
  - state encoding (LIMPANDO=1'b0, OCIOSO=1'b1)
  - derived-width helper constants (BITS_END, PROFUNDIDADE) as localparam functions of the parameters
- Sub-module ram_banco: one bank.
  - Parameters: LARGURA, BITS_PALAVRA.
  - Ports: clock_principal, habilita_write, endereco_palavra, dados_entrada, dados_saida (combinational read).
  - Instantiated 2^BITS_BANCO times via generate.
- Top level contains:
  - write-enable decoder (generalised dmux)
  - bank output mux (generalised N-way mux)
  - clear FSM/counter
  - address/data muxing between clear and user paths
  - output register

Test Plan:
- Reset then idle, defaults (16/3/3): pronto=0 for 64 cycles after reset_n rises, pronto=1 at cycle 64. Read addr 0x2A -> dados_saida=0x0000, saida_valida=1 one cycle later.
- Write 0xBEEF@0x09, 0x1234@0x3F, 0xA5A5@0x00, then read each -> same values with 1-cycle latency. Neighbouring 0x08/0x0A/0x31 read 0.
- Same-cycle write 0x5555 and read @0x12 -> next cycle dados_saida=0x5555, saida_valida=1.
- Write 0xFFFF@0x20 while pronto=0 (during clear) -> after clear, read @0x20 = 0x0000; no saida_valida during clear.
- After writing 0x7777@0x15, pulse comando_limpar with a same-cycle write @0x16 -> pronto low 64 cycles; then both addresses read 0x0000.
- reset_n low for one cycle mid-read and mid-clear (cycle 30) -> saida_valida=0 next cycle; clear restarts, pronto rises exactly 64 cycles after release.
- Rerun all of the above with LARGURA=8, BITS_BANCO=2, BITS_PALAVRA=4: pronto at cycle 64, data masked to 8 bits.
